// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Each granted access holds mem_en for MEM_LAT cycles, then pulses ready.
module mem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int MEM_LAT      = 2,
  parameter int MAX_D_STREAK = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          gnt_if,
  output logic          gnt_dm
);

  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [SW-1:0] streak, streak_nx;
  logic          owner, owner_nx;
  logic          we_r;
  logic          grant_dm, grant_if;
  logic          start, done;

  always_comb begin
    grant_dm  = dm_req &&
                (!if_req || streak != SW'(MAX_D_STREAK));
    grant_if  = if_req && !grant_dm;
    start     = (state == IDLE) && (grant_dm || grant_if);
    done      = (state == ACCESS) && (cnt == '0);
    state_nx  = state;
    cnt_nx    = cnt;
    streak_nx = streak;
    owner_nx  = owner;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = ACCESS;
          cnt_nx   = CW'(MEM_LAT - 1);
          owner_nx = grant_dm;
          // streak only grows while a fetch is actually waiting
          streak_nx = (grant_dm && if_req) ?
                      streak + SW'(1) : '0;
        end
      end
      ACCESS: begin
        if (done) state_nx = IDLE;
        else      cnt_nx   = cnt - CW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      streak    <= '0;
      owner     <= 1'b0;
      we_r      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      streak   <= streak_nx;
      owner    <= owner_nx;
      if_ready <= done && !owner;
      dm_ready <= done && owner;
      if (start) begin
        we_r     <= grant_dm && dm_we;
        mem_addr <= grant_dm ? dm_addr : if_addr;
        if (grant_dm) mem_wdata <= dm_wdata;
      end
      if (done && !owner)
        if_rdata <= mem_rdata;
      if (done && owner && !we_r)
        dm_rdata <= mem_rdata;
    end
  end

  assign mem_en = (state == ACCESS);
  assign mem_we = mem_en && we_r;
  assign gnt_if = mem_en && !owner;
  assign gnt_dm = mem_en && owner;

endmodule
